// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared widths and FSM state type for the register-file dump engine
package reg_dump_pkg;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - spare register-file read port plus the (index, data) beat stream
interface reg_dump_if #(
   parameter int ADDR_W = reg_dump_pkg::ADDR_W,
   parameter int DATA_W = reg_dump_pkg::DATA_W
);
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_index;
   logic [DATA_W-1:0] out_data;

   modport master (
      output rf_addr,
      input  rf_data,
      output out_valid,
      input  out_ready,
      output out_index,
      output out_data
   );

   modport slave (
      input  rf_addr,
      output rf_data,
      input  out_valid,
      output out_ready,
      input  out_index,
      input  out_data
   );
endinterface

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - walks the register file through a spare read port and streams each word plus an XOR checksum
module reg_dump #(
   parameter int NUM_REGS = reg_dump_pkg::NUM_REGS,
   parameter int ADDR_W   = reg_dump_pkg::ADDR_W,
   parameter int DATA_W   = reg_dump_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum,
   reg_dump_if.master        bus
);
   import reg_dump_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] index_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] sum_q;
   logic              accept;
   logic              last;

   // abort suppresses acceptance so a cancelled beat never reaches the checksum
   assign accept = (state == SEND) && bus.out_ready && !abort;
   assign last   = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = SEND;
            SEND:    if (bus.out_ready) state_nxt = last ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.rf_addr   = (state == READ) ? idx : '0;
      bus.out_valid = (state == SEND);
      bus.out_index = index_q;
      bus.out_data  = data_q;
      busy          = (state != IDLE);
      done          = (state == DONE);
      checksum      = sum_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= '0;
         index_q <= '0;
         data_q  <= '0;
         sum_q   <= '0;
      end else begin
         if (state == IDLE && start && !abort) begin
            idx   <= '0;
            sum_q <= '0;
         end
         if (state == READ && !abort) begin
            data_q  <= bus.rf_data;
            index_q <= idx;
         end
         if (accept) begin
            sum_q <= sum_q ^ data_q;
            if (!last) idx <= idx + ADDR_W'(1);
         end
      end
   end
endmodule
